// File: rtl/intr_ctrl.sv
// ============================================================================
// intr_ctrl : edge-triggered, masked, fixed-priority interrupt controller for CP0
//             (optional internal timer on source 0 via INTR_TIMER_EN) -- rev 1.0
// ============================================================================
`default_nettype none

module intr_ctrl #(
   parameter int N_SRC   = 8,
   parameter int TIMER_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] src_in,
   input  logic             wr_en,
   input  logic [1:0]       wr_addr,
   input  logic [31:0]      wr_data,
   input  logic [1:0]       rd_addr,
   output logic [31:0]      rd_data,
   output logic             ir_out,
   input  logic             ack_in,
   input  logic             eoi_in,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SVC  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [N_SRC-1:0] mask, pending, src_prev;
   logic [N_SRC-1:0] edge_det, set_bits, clr_bits, active;
   logic [4:0]       sel_id, sel_id_nxt, cause_id, win_id;
   logic             ack_take;
   logic             tmr_hit;
   logic             unused_wr;

   assign unused_wr = ^wr_data;
   assign edge_det  = src_in & ~src_prev;
   assign active    = pending & mask;
   assign ack_take  = (state == ST_REQ) && ack_in;

`ifdef INTR_TIMER_EN
   localparam int CMP_RD_W = (TIMER_W < 32) ? TIMER_W : 32;

   logic [TIMER_W-1:0] tmr_cnt, tmr_cmp;

   assign tmr_hit = (tmr_cmp != '0) && (tmr_cnt == tmr_cmp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr_cnt <= '0;
         tmr_cmp <= '0;
      end else if (wr_en && (wr_addr == 2'd3)) begin
         tmr_cmp <= TIMER_W'(wr_data);
         tmr_cnt <= '0;
      end else if (tmr_hit) begin
         tmr_cnt <= '0;
      end else begin
         tmr_cnt <= tmr_cnt + TIMER_W'(1);
      end
   end

   // The timer owns source 0; the external line 0 is deliberately dropped.
   always_comb begin
      set_bits    = edge_det;
      set_bits[0] = tmr_hit;
   end
`else
   localparam int unused_timer_w = TIMER_W;

   assign tmr_hit  = 1'b0;
   assign set_bits = edge_det;
`endif

   always_comb begin
      clr_bits = '0;
      if (wr_en && (wr_addr == 2'd1)) begin
         clr_bits = wr_data[N_SRC-1:0];
      end
      for (int i = 0; i < N_SRC; i++) begin
         if (ack_take && (sel_id == 5'(i))) begin
            clr_bits[i] = 1'b1;
         end
      end
   end

   // Lowest index wins: scan downward so the last hit is the smallest.
   always_comb begin
      win_id = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (active[i]) begin
            win_id = 5'(i);
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      sel_id_nxt = sel_id;
      case (state)
         ST_IDLE: begin
            if (|active) begin
               sel_id_nxt = win_id;
               state_nxt  = ST_REQ;
            end
         end
         ST_REQ: begin
            if (ack_in) begin
               state_nxt = ST_SVC;
            end
         end
         ST_SVC: begin
            if (eoi_in) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         sel_id   <= '0;
         cause_id <= '0;
         ir_out   <= 1'b0;
         busy     <= 1'b0;
         mask     <= '0;
         pending  <= '0;
         src_prev <= '0;
      end else begin
         state    <= state_nxt;
         sel_id   <= sel_id_nxt;
         ir_out   <= (state_nxt == ST_REQ);
         busy     <= (state_nxt == ST_SVC);
         src_prev <= src_in;
         // A new edge outranks a same-cycle clear of the same bit.
         pending  <= (pending & ~clr_bits) | set_bits;
         if (ack_take) begin
            cause_id <= sel_id;
         end
         if (wr_en && (wr_addr == 2'd0)) begin
            mask <= wr_data[N_SRC-1:0];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      case (rd_addr)
         2'd0: rd_data[N_SRC-1:0] = mask;
         2'd1: rd_data[N_SRC-1:0] = pending;
         2'd2: begin
            rd_data[31]  = busy;
            rd_data[4:0] = cause_id;
         end
         default: begin
`ifdef INTR_TIMER_EN
            rd_data[CMP_RD_W-1:0] = tmr_cmp[CMP_RD_W-1:0];
`endif
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_intr_ctrl.sv
// ============================================================================
// tb_intr_ctrl : scoreboard bench for intr_ctrl (timer steps under INTR_TIMER_EN)
// ============================================================================
`default_nettype none

module tb_intr_ctrl;

   localparam int N_SRC   = 8;
   localparam int TIMER_W = 32;
`ifdef INTR_TIMER_EN
   localparam int RS = 1;
`else
   localparam int RS = 0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N_SRC-1:0] src_in = '0;
   logic             wr_en = 1'b0;
   logic [1:0]       wr_addr = '0;
   logic [31:0]      wr_data = '0;
   logic [1:0]       rd_addr = '0;
   logic [31:0]      rd_data;
   logic             ir_out;
   logic             ack_in = 1'b0;
   logic             eoi_in = 1'b0;
   logic             busy;

   intr_ctrl #(.N_SRC(N_SRC), .TIMER_W(TIMER_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .src_in  (src_in),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .ir_out  (ir_out),
      .ack_in  (ack_in),
      .eoi_in  (eoi_in),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic observe(input logic [31:0] got);
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_underflow: got 0x%08h expected nothing", got);
      end else begin
         e = sb.pop_front();
         check(e.tag, got, e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic obs_reg(input logic [1:0] a);
      rd_addr = a;
      #1;
      observe(rd_data);
   endtask

   task automatic obs_ir();
      observe({31'b0, ir_out});
   endtask

   task automatic obs_busy();
      observe({31'b0, busy});
   endtask

   task automatic pulse_ack();
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
   endtask

   task automatic pulse_eoi();
      eoi_in = 1'b1;
      tick();
      eoi_in = 1'b0;
   endtask

   initial begin
      // ---------------- reset state
      #2;
      push("rst_ir", 0);      obs_ir();
      push("rst_busy", 0);    obs_busy();
      push("rst_mask", 0);    obs_reg(2'd0);
      push("rst_pend", 0);    obs_reg(2'd1);
      push("rst_cause", 0);   obs_reg(2'd2);
      push("rst_tcmp", 0);    obs_reg(2'd3);
      ticks(2);
      rst_n = 1'b1;
      ticks(2);

      // ---------------- priority: src 5 and 2 together
      wr(2'd0, 32'hFF);
      push("mask_rb", 32'hFF); obs_reg(2'd0);
      src_in = 8'h24;
      push("pri_ir_t1", 0);
      push("pri_pend_t1", 32'h24);
      tick();
      obs_ir(); obs_reg(2'd1);
      push("pri_ir_t2", 1);
      tick();
      obs_ir();
      push("pri_ir_after_ack", 0);
      push("pri_busy_after_ack", 1);
      push("pri_cause_2", 32'h8000_0002);
      push("pri_pend_after_ack", 32'h20);
      pulse_ack();
      obs_ir(); obs_busy(); obs_reg(2'd2); obs_reg(2'd1);
      src_in = '0;
      push("pri_busy_after_eoi", 0);
      push("pri_ir_eoi_t1", 0);
      pulse_eoi();
      obs_busy(); obs_ir();
      push("pri_ir_eoi_t2", 1);
      tick();
      obs_ir();
      push("pri_cause_5", 32'h8000_0005);
      push("pri_pend_empty", 0);
      pulse_ack();
      obs_reg(2'd2); obs_reg(2'd1);
      push("pri_cause_idle", 32'h0000_0005);
      pulse_eoi();
      obs_reg(2'd2);

      // ---------------- masking and freeze
      wr(2'd0, 32'h00);
      src_in = 8'h08;
      tick();
      src_in = '0;
      ticks(2);
      push("msk_pend", 32'h08); obs_reg(2'd1);
      push("msk_ir_off", 0);    obs_ir();
      wr(2'd0, 32'h08);
      push("msk_ir_wr_cycle", 0);
      obs_ir();
      push("msk_ir_on", 1);
      tick();
      obs_ir();
      wr(2'd0, 32'h00);
      tick();
      push("frz_ir_held", 1); obs_ir();
      push("frz_cause_3", 32'h8000_0003);
      pulse_ack();
      obs_reg(2'd2);
      pulse_eoi();

      // ---------------- stray handshakes
      push("stray_ack_ir", 0);
      push("stray_ack_busy", 0);
      push("stray_ack_cause", 32'h0000_0003);
      pulse_ack();
      obs_ir(); obs_busy(); obs_reg(2'd2);
      wr(2'd0, 32'h10);
      src_in = 8'h10;
      ticks(2);
      src_in = '0;
      push("stray_req_ir", 1); obs_ir();
      push("stray_eoi_ir", 1);
      push("stray_eoi_busy", 0);
      pulse_eoi();
      obs_ir(); obs_busy();
      // ack and eoi together in REQ: ack wins
      ack_in = 1'b1;
      eoi_in = 1'b1;
      tick();
      ack_in = 1'b0;
      eoi_in = 1'b0;
      push("both_busy", 1); obs_busy();
      push("both_ir", 0);   obs_ir();
      pulse_eoi();
      push("both_eoi_busy", 0); obs_busy();

      // ---------------- set/clear collision on PENDING[1]
      src_in = 8'h02;
      wr(2'd1, 32'h02);
      push("coll_set_wins", 32'h02); obs_reg(2'd1);
      wr(2'd1, 32'h02);
      push("coll_clear", 32'h00); obs_reg(2'd1);
      push("coll_ir_masked", 0);  obs_ir();

      // ---------------- reset while in REQ
      src_in = '0;
      wr(2'd0, 32'(1) << RS);
      src_in[RS] = 1'b1;
      ticks(2);
      push("rreq_ir", 1); obs_ir();
      rst_n  = 1'b0;
      src_in = '0;
      #1;
      push("rreq_ir_now", 0);  obs_ir();
      push("rreq_pend", 0);    obs_reg(2'd1);
      push("rreq_mask", 0);    obs_reg(2'd0);
      tick();
      rst_n = 1'b1;
      ticks(3);
      push("rreq_idle_ir", 0);   obs_ir();
      push("rreq_idle_busy", 0); obs_busy();

`ifdef INTR_TIMER_EN
      // ---------------- timer: period cmp+1
      wr(2'd0, 32'h01);
      wr(2'd3, 32'd10);
      push("tmr_cmp_rb", 32'd10); obs_reg(2'd3);
      ticks(10);
      push("tmr_pend_pre", 0); obs_reg(2'd1);
      tick();
      push("tmr_pend_hit", 1); obs_reg(2'd1);
      push("tmr_ir_pre", 0);   obs_ir();
      tick();
      push("tmr_ir_hit", 1);   obs_ir();
      pulse_ack();
      pulse_eoi();
      ticks(7);
      push("tmr_pend_pre2", 0); obs_reg(2'd1);
      tick();
      push("tmr_pend_hit2", 1); obs_reg(2'd1);
      wr(2'd3, 32'd0);
      pulse_ack();
      pulse_eoi();
      ticks(30);
      push("tmr_stopped", 0); obs_reg(2'd1);
`endif

      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt controller that drives the CPU coprocessor's external interrupt input. It collects up to N_SRC edge-triggered requests, applies a software mask and fixed priority, and raises a single interrupt request. It then follows the coprocessor through acceptance (ack) and exception return (eoi), and exposes mask, pending and cause registers on a small register port. It sits between peripherals and CP0, in the same clock domain as the pipeline.

## Interface
- N_SRC, 8: number of request sources, 2..32.
- TIMER_W, 32: width of the optional internal timer counter and compare register.

- clk  in  1  main clock
- rst_n  in  1  asynchronous, active-low reset
- src_in  in  N_SRC  level request lines, synchronous to clk; a rising edge posts a request
- wr_en  in  1  register write strobe
- wr_addr  in  2  register write address
- wr_data  in  32  register write data
- rd_addr  in  2  register read address
- rd_data  out  32  register read data, combinational from rd_addr
- ir_out  out  1  interrupt request to CP0 ir_in
- ack_in  in  1  one-cycle pulse: CP0 accepted the interrupt (jump taken to handler)
- eoi_in  in  1  one-cycle pulse: ERET executed
- busy  out  1  high while an interrupt is in service

## Operation
- Edge detect: src_prev is registered from src_in. A rising edge on bit i (src_in[i] & ~src_prev[i]) sets PENDING[i] on the next clk.
- Registers, read and write:
  - 0 MASK: RW, 1 = enabled.
  - 1 PENDING: R; writing 1 clears the bit. On the same bit in the same cycle, set beats clear.
  - 2 CAUSE: R; bit31 = busy, [4:0] = id in service or last serviced.
  - 3 TIMER_CMP: RW when timer compiled in, otherwise reads 0 and ignores writes.
- Priority: lowest set index of (PENDING & MASK) wins.
- FSM states:
  - IDLE: if (PENDING & MASK) != 0, latch winner id into sel_id and go to REQ.
  - REQ: ir_out = 1. sel_id stays frozen even if MASK or PENDING change. On ack_in: clear PENDING[sel_id], CAUSE.id <= sel_id, go to SVC.
  - SVC: busy = 1. New requests keep posting to PENDING but are not forwarded. On eoi_in go to IDLE.
- Ignored inputs: ack_in outside REQ; eoi_in outside SVC.
- ack_in and eoi_in together in REQ: ack is taken, eoi is ignored, and the FSM lands in SVC.
- Unused bits: rd_data bits above N_SRC read 0. Writes to bits above N_SRC are ignored.

## Timing
- Reset (rst_n low, any state, immediately): FSM = IDLE; MASK, PENDING, CAUSE, TIMER_CMP, timer count and src_prev = 0; ir_out = 0, busy = 0.
- Edge at cycle t (sampled) -> PENDING set at t+1 -> FSM in REQ and ir_out = 1 at t+2, provided the source is unmasked and the FSM was idle.
- ir_out is registered and stays high every cycle in REQ until the clk edge that samples ack_in. ir_out = 0 from the next cycle.
- busy rises in the cycle after ack_in and falls in the cycle after eoi_in.
- IDLE re-evaluates on the first cycle after leaving SVC. A request still pending therefore reasserts ir_out 2 cycles after eoi_in.
- A MASK write takes effect on the FSM evaluation of the following cycle.
- rd_data has zero latency and reflects register state before any same-cycle write.

## Configuration
- INTR_TIMER_EN defined: internal TIMER_W-bit counter increments every clk.
  - When TIMER_CMP != 0 and count == TIMER_CMP: PENDING[0] is set and count returns to 0.
  - Writing TIMER_CMP also zeroes count.
  - src_in[0] is ignored.
- INTR_TIMER_EN undefined: no counter; src_in[0] is an ordinary external source; address 3 reads 0.

## Test plan
- Reset mid-REQ: MASK=0x01, pulse src_in[0], assert rst_n low while ir_out=1 -> ir_out=0, PENDING=0, MASK=0 at once; after release, state stays idle with no ir_out.
- Priority: MASK=0xFF, raise src_in[5] and src_in[2] in the same cycle -> ir_out high 2 cycles later; ack -> CAUSE=0x80000002, PENDING=0x20; eoi -> ir_out high again 2 cycles later; ack -> CAUSE.id=5.
- Masking/freeze: MASK=0x00, edge on src_in[3] -> PENDING=0x08, ir_out stays 0. Write MASK=0x08 -> ir_out rises. Write MASK=0 while in REQ -> ir_out stays high; ack services id 3.
- Set/clear collision: edge on src_in[1] in the same cycle as a write of 0x02 to PENDING -> PENDING[1]=1.
- Stray handshakes: ack_in in IDLE and eoi_in in REQ -> no state change, ir_out unchanged.
- Timer (INTR_TIMER_EN): TIMER_CMP=10, MASK=0x01 -> PENDING[0] sets every 11 cycles; ir_out rises 1 cycle after PENDING[0]; TIMER_CMP=0 stops further sets.
